// File: rtl/reg_write_issuer.sv
// rtl/reg_write_issuer.sv - register-file write issuer merging pipeline writeback and UART load words
// Optional R0_GUARD_EN: r-file register 0 writes are accepted/completed but never issued.
module reg_write_issuer #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_rd,
    input  logic        wb_float,
    input  logic [31:0] wb_data,
    input  logic        uart_start,
    input  logic [4:0]  uart_rd,
    input  logic        uart_float,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rx_ready,
    output logic        uart_busy,
    output logic        RegWrite,
    output logic        UART_write_enable,
    output logic        distinct,
    output logic        AorF_before,
    output logic [4:0]  rw,
    output logic [31:0] write_data
);

    typedef enum logic [1:0] {S_IDLE, S_ASM, S_PEND} uart_state_t;

    uart_state_t state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [3:0]  starve_q, starve_d;
    logic [4:0]  load_rd_q, load_rd_d;
    logic        load_float_q, load_float_d;
    logic [31:0] load_word_q, load_word_d;
    logic        shadow_q, shadow_d;
    logic        regwrite_q, regwrite_d;
    logic        uwe_q, uwe_d;
    logic        distinct_q, distinct_d;
    logic        aorf_q, aorf_d;
    logic [4:0]  rw_q, rw_d;
    logic [31:0] wdata_q, wdata_d;

    logic uart_grant;
    logic wb_issue;
    logic wb_drop;
    logic uart_drop;

    assign uart_grant = (state_q == S_PEND) && (!wb_valid || (starve_q >= 4'(STARVE_LIMIT)));
    assign wb_ready   = !uart_grant;
    assign wb_issue   = wb_valid && !uart_grant;
    assign rx_ready   = (state_q == S_ASM);
    assign uart_busy  = (state_q != S_IDLE);

`ifdef R0_GUARD_EN
    assign wb_drop   = !wb_float && (wb_rd == 5'd0);
    assign uart_drop = !load_float_q && (load_rd_q == 5'd0);
`else
    assign wb_drop   = 1'b0;
    assign uart_drop = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= 2'd0;
            starve_q     <= 4'd0;
            load_rd_q    <= 5'd0;
            load_float_q <= 1'b0;
            load_word_q  <= 32'd0;
            shadow_q     <= 1'b0;
            regwrite_q   <= 1'b0;
            uwe_q        <= 1'b0;
            distinct_q   <= 1'b0;
            aorf_q       <= 1'b0;
            rw_q         <= 5'd0;
            wdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            starve_q     <= starve_d;
            load_rd_q    <= load_rd_d;
            load_float_q <= load_float_d;
            load_word_q  <= load_word_d;
            shadow_q     <= shadow_d;
            regwrite_q   <= regwrite_d;
            uwe_q        <= uwe_d;
            distinct_q   <= distinct_d;
            aorf_q       <= aorf_d;
            rw_q         <= rw_d;
            wdata_q      <= wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        starve_d     = starve_q;
        load_rd_d    = load_rd_q;
        load_float_d = load_float_q;
        load_word_d  = load_word_q;
        shadow_d     = shadow_q;
        regwrite_d   = 1'b0;
        uwe_d        = 1'b0;
        distinct_d   = shadow_q;
        aorf_d       = aorf_q;
        rw_d         = rw_q;
        wdata_d      = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (uart_start) begin
                    load_rd_d    = uart_rd;
                    load_float_d = uart_float;
                    byte_cnt_d   = 2'd0;
                    starve_d     = 4'd0;
                    state_d      = S_ASM;
                end
            end
            S_ASM: begin
                // Big-endian assembly: first byte ends up in [31:24].
                if (rx_valid) begin
                    load_word_d = {load_word_q[23:0], rx_byte};
                    byte_cnt_d  = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_PEND;
                    end
                end
            end
            S_PEND: begin
                if (uart_grant) begin
                    starve_d = 4'd0;
                    state_d  = S_IDLE;
                end else if (wb_valid && (starve_q != 4'd15)) begin
                    starve_d = starve_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // UART writes force the toggle to 1 because the register file accepts them whenever distinct is set.
        if (uart_grant) begin
            if (!uart_drop) begin
                uwe_d      = 1'b1;
                distinct_d = 1'b1;
                rw_d       = load_rd_q;
                aorf_d     = load_float_q;
                wdata_d    = load_word_q;
                shadow_d   = 1'b1;
            end
        end else if (wb_issue && !wb_drop) begin
            regwrite_d = 1'b1;
            distinct_d = ~shadow_q;
            rw_d       = wb_rd;
            aorf_d     = wb_float;
            wdata_d    = wb_data;
            shadow_d   = ~shadow_q;
        end
    end

    assign RegWrite          = regwrite_q;
    assign UART_write_enable = uwe_q;
    assign distinct          = distinct_q;
    assign AorF_before       = aorf_q;
    assign rw                = rw_q;
    assign write_data        = wdata_q;

endmodule

// File: tb/tb_reg_write_issuer.sv
// tb/tb_reg_write_issuer.sv - self-checking bench for reg_write_issuer with a register-file model
module tb_reg_write_issuer;

    localparam int STARVE_LIMIT = 4;

    logic        CLK = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic        wb_float;
    logic [31:0] wb_data;
    logic        uart_start;
    logic [4:0]  uart_rd;
    logic        uart_float;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_ready;
    logic        uart_busy;
    logic        RegWrite;
    logic        UART_write_enable;
    logic        distinct;
    logic        AorF_before;
    logic [4:0]  rw;
    logic [31:0] write_data;

    int checks = 0;
    int fails  = 0;

    reg_write_issuer #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .CLK(CLK), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_float(wb_float), .wb_data(wb_data),
        .uart_start(uart_start), .uart_rd(uart_rd), .uart_float(uart_float),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rx_ready), .uart_busy(uart_busy),
        .RegWrite(RegWrite), .UART_write_enable(UART_write_enable), .distinct(distinct),
        .AorF_before(AorF_before), .rw(rw), .write_data(write_data)
    );

    always #5 CLK = ~CLK;

    // Register file as the environment sees it: writes only under its own toggle condition.
    logic [31:0] rf_r [32];
    logic [31:0] rf_f [32];
    logic        rf_buf;
    int          wr_count = 0;

    always @(posedge CLK) begin
        if (reset) begin
            rf_buf <= 1'b0;
        end else if ((RegWrite && (distinct != rf_buf)) || (UART_write_enable && distinct)) begin
            if (AorF_before) rf_f[rw] <= write_data;
            else             rf_r[rw] <= write_data;
            rf_buf   <= distinct;
            wr_count <= wr_count + 1;
        end
    end

    task automatic do_reset();
        reset = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_float = 1'b0; wb_data = '0;
        uart_start = 1'b0; uart_rd = '0; uart_float = 1'b0; rx_valid = 1'b0; rx_byte = '0;
        repeat (2) @(negedge CLK);
        reset = 1'b0;
    endtask

    task automatic uart_begin(input logic [4:0] rd, input logic fl);
        @(negedge CLK);
        uart_start = 1'b1; uart_rd = rd; uart_float = fl;
        @(negedge CLK);
        uart_start = 1'b0;
    endtask

    task automatic uart_bytes(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_byte  = w[31-8*i -: 8];
            @(negedge CLK);
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({RegWrite, UART_write_enable, distinct, AorF_before, rw, write_data} !== 40'd0) begin
            fails++; $display("FAIL reset_outputs: got %h expected 0",
                {RegWrite, UART_write_enable, distinct, AorF_before, rw, write_data});
        end
        checks++;
        if ({uart_busy, rx_ready, wb_ready} !== 3'b001) begin
            fails++; $display("FAIL reset_status: busy/rx_ready/wb_ready got %b expected 001",
                {uart_busy, rx_ready, wb_ready});
        end
    endtask

    task automatic test_single_wb();
        int base;
        base = wr_count;
        @(negedge CLK);
        wb_valid = 1'b1; wb_rd = 5'd3; wb_float = 1'b0; wb_data = 32'h12345678;
        @(negedge CLK);
        wb_valid = 1'b0;
        checks++;
        if ({RegWrite, UART_write_enable, distinct, rw, write_data} !== {3'b101, 5'd3, 32'h12345678}) begin
            fails++; $display("FAIL single_wb_issue: RegWrite=%b UWE=%b distinct=%b rw=%0d data=%h expected 1 0 1 3 12345678",
                RegWrite, UART_write_enable, distinct, rw, write_data);
        end
        @(negedge CLK);
        checks++;
        if (rf_r[3] !== 32'h12345678 || RegWrite !== 1'b0 || wr_count - base != 1) begin
            fails++; $display("FAIL single_wb_commit: r3=%h RegWrite=%b writes=%0d expected 12345678 0 1",
                rf_r[3], RegWrite, wr_count - base);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        logic [31:0] d [3];
        do_reset();
        base = wr_count;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (k > 0) begin
                checks++;
                if (RegWrite !== 1'b1 || distinct !== logic'(k % 2) || rw !== 5'(k)) begin
                    fails++; $display("FAIL b2b_issue%0d: RegWrite=%b distinct=%b rw=%0d expected 1 %0d %0d",
                        k, RegWrite, distinct, rw, k % 2, k);
                end
            end
            if (k < 3) begin
                d[k] = $urandom;
                wb_valid = 1'b1; wb_rd = 5'(k + 1); wb_float = 1'b0; wb_data = d[k];
                #1;
                checks++;
                if (wb_ready !== 1'b1) begin
                    fails++; $display("FAIL b2b_ready%0d: got %b expected 1", k, wb_ready);
                end
            end else begin
                wb_valid = 1'b0;
            end
        end
        @(negedge CLK);
        checks++;
        if (wr_count - base != 3 || rf_r[1] !== d[0] || rf_r[2] !== d[1] || rf_r[3] !== d[2]) begin
            fails++; $display("FAIL b2b_commit: writes=%0d r1=%h r2=%h r3=%h expected 3 %h %h %h",
                wr_count - base, rf_r[1], rf_r[2], rf_r[3], d[0], d[1], d[2]);
        end
    endtask

    task automatic test_uart_load();
        int base, hits;
        logic d_seen, a_seen;
        base = wr_count; hits = 0; d_seen = 1'b0; a_seen = 1'b0;
        uart_begin(5'd5, 1'b1);
        checks++;
        if (rx_ready !== 1'b1 || uart_busy !== 1'b1) begin
            fails++; $display("FAIL uart_asm_status: rx_ready=%b busy=%b expected 1 1", rx_ready, uart_busy);
        end
        uart_bytes(32'hDEADBEEF, 4);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (UART_write_enable) begin
                hits++; d_seen = distinct; a_seen = AorF_before;
            end
        end
        checks++;
        if (hits != 1 || d_seen !== 1'b1 || a_seen !== 1'b1) begin
            fails++; $display("FAIL uart_strobe: cycles=%0d distinct=%b AorF=%b expected 1 1 1", hits, d_seen, a_seen);
        end
        checks++;
        if (rf_f[5] !== 32'hDEADBEEF || wr_count - base != 1 || uart_busy !== 1'b0) begin
            fails++; $display("FAIL uart_commit: f5=%h writes=%0d busy=%b expected deadbeef 1 0",
                rf_f[5], wr_count - base, uart_busy);
        end
    endtask

    task automatic test_starvation();
        int base, j;
        logic [31:0] uw;
        logic [31:0] d [10];
        base = wr_count; j = 0; uw = $urandom;
        uart_begin(5'd7, 1'b1);
        uart_bytes(uw, 4);
        for (int k = 0; k < 10; k++) begin
            if (k == STARVE_LIMIT + 1) begin
                checks++;
                if (UART_write_enable !== 1'b1 || RegWrite !== 1'b0) begin
                    fails++; $display("FAIL starve_uart_issue: UWE=%b RegWrite=%b expected 1 0", UART_write_enable, RegWrite);
                end
            end
            if (k == 0 || wb_ready) d[j] = $urandom;
            wb_valid = 1'b1; wb_rd = 5'(10 + j); wb_float = 1'b0; wb_data = d[j];
            #1;
            checks++;
            if (wb_ready !== (k != STARVE_LIMIT)) begin
                fails++; $display("FAIL starve_ready%0d: got %b expected %b", k, wb_ready, k != STARVE_LIMIT);
            end
            if (wb_ready) j++;
            @(negedge CLK);
        end
        wb_valid = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (wr_count - base != j + 1 || rf_f[7] !== uw) begin
            fails++; $display("FAIL starve_commit: writes=%0d f7=%h expected %0d %h", wr_count - base, rf_f[7], j + 1, uw);
        end
        for (int i = 0; i < j; i++) begin
            checks++;
            if (rf_r[10 + i] !== d[i]) begin
                fails++; $display("FAIL starve_reg%0d: got %h expected %h", 10 + i, rf_r[10 + i], d[i]);
            end
        end
    endtask

    task automatic test_uart_then_wb();
        logic [31:0] uw, pw;
        uw = $urandom; pw = $urandom;
        uart_begin(5'd9, 1'b1);
        uart_bytes(uw, 4);
        @(negedge CLK);
        checks++;
        if (UART_write_enable !== 1'b1 || distinct !== 1'b1) begin
            fails++; $display("FAIL uw_uart: UWE=%b distinct=%b expected 1 1", UART_write_enable, distinct);
        end
        wb_valid = 1'b1; wb_rd = 5'd20; wb_float = 1'b0; wb_data = pw;
        @(negedge CLK);
        wb_valid = 1'b0;
        checks++;
        if (RegWrite !== 1'b1 || distinct !== 1'b0 || UART_write_enable !== 1'b0) begin
            fails++; $display("FAIL uw_wb: RegWrite=%b distinct=%b UWE=%b expected 1 0 0", RegWrite, distinct, UART_write_enable);
        end
        @(negedge CLK);
        checks++;
        if (rf_f[9] !== uw || rf_r[20] !== pw) begin
            fails++; $display("FAIL uw_commit: f9=%h r20=%h expected %h %h", rf_f[9], rf_r[20], uw, pw);
        end
    endtask

    task automatic test_reset_mid_assembly();
        logic [31:0] w;
        w = $urandom;
        uart_begin(5'd11, 1'b1);
        uart_bytes(32'hCAFEF00D, 2);
        reset = 1'b1;
        @(negedge CLK);
        checks++;
        if (uart_busy !== 1'b0 || rx_ready !== 1'b0) begin
            fails++; $display("FAIL mid_reset: busy=%b rx_ready=%b expected 0 0", uart_busy, rx_ready);
        end
        reset = 1'b0;
        uart_begin(5'd11, 1'b1);
        uart_bytes(w, 4);
        repeat (3) @(negedge CLK);
        checks++;
        if (rf_f[11] !== w) begin
            fails++; $display("FAIL mid_reset_reload: f11=%h expected %h", rf_f[11], w);
        end
    endtask

    task automatic test_r0();
        do_reset();
        @(negedge CLK);
        wb_valid = 1'b1; wb_rd = 5'd0; wb_float = 1'b0; wb_data = 32'hA5A5A5A5;
        #1;
        checks++;
        if (wb_ready !== 1'b1) begin
            fails++; $display("FAIL r0_ready: got %b expected 1", wb_ready);
        end
        @(negedge CLK);
        wb_rd = 5'd1; wb_data = 32'h0BADF00D;
`ifdef R0_GUARD_EN
        checks++;
        if (RegWrite !== 1'b0 || distinct !== 1'b0) begin
            fails++; $display("FAIL r0_drop: RegWrite=%b distinct=%b expected 0 0", RegWrite, distinct);
        end
        @(negedge CLK);
        wb_valid = 1'b0;
        checks++;
        if (RegWrite !== 1'b1 || distinct !== 1'b1 || rw !== 5'd1) begin
            fails++; $display("FAIL r0_next: RegWrite=%b distinct=%b rw=%0d expected 1 1 1", RegWrite, distinct, rw);
        end
`else
        checks++;
        if (RegWrite !== 1'b1 || distinct !== 1'b1 || rw !== 5'd0) begin
            fails++; $display("FAIL r0_issue: RegWrite=%b distinct=%b rw=%0d expected 1 1 0", RegWrite, distinct, rw);
        end
        @(negedge CLK);
        wb_valid = 1'b0;
        checks++;
        if (RegWrite !== 1'b1 || distinct !== 1'b0 || rw !== 5'd1) begin
            fails++; $display("FAIL r0_next: RegWrite=%b distinct=%b rw=%0d expected 1 0 1", RegWrite, distinct, rw);
        end
`endif
        @(negedge CLK);
    endtask

    task automatic test_random_mix();
        logic [31:0] exp_r [32];
        logic [31:0] exp_f [32];
        logic [31:0] mask_r, mask_f, cur_word;
        int base, expected_writes, byte_idx, budget;
        logic pending, prev_uwe;
        mask_r = '0; mask_f = '0; base = wr_count; expected_writes = 0;
        byte_idx = 0; pending = 1'b0; prev_uwe = 1'b0; cur_word = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            checks++;
            if (UART_write_enable && prev_uwe) begin
                fails++; $display("FAIL rand_uwe_repeat: cycle %0d UWE high twice", c);
            end
            prev_uwe = UART_write_enable;
            if (!pending) begin
                wb_valid = ($urandom_range(0, 1) == 1);
                wb_rd = 5'($urandom_range(1, 31)); wb_float = 1'b0; wb_data = $urandom;
            end
            uart_start = 1'b0; rx_valid = 1'b0;
            if (!uart_busy && $urandom_range(0, 3) == 0) begin
                uart_start = 1'b1; uart_rd = 5'($urandom_range(0, 31)); uart_float = 1'b1;
                cur_word = $urandom; byte_idx = 0;
                exp_f[uart_rd] = cur_word; mask_f[uart_rd] = 1'b1; expected_writes++;
            end else if (rx_ready && byte_idx < 4 && $urandom_range(0, 1) == 1) begin
                rx_valid = 1'b1; rx_byte = cur_word[31-8*byte_idx -: 8];
            end
            #1;
            if (wb_valid && wb_ready) begin
                exp_r[wb_rd] = wb_data; mask_r[wb_rd] = 1'b1; expected_writes++; pending = 1'b0;
            end else begin
                pending = wb_valid;
            end
            if (rx_valid && rx_ready) byte_idx++;
        end
        wb_valid = 1'b0; uart_start = 1'b0;
        budget = 0;
        while ((uart_busy || pending) && budget < 50) begin
            if (pending) begin
                wb_valid = 1'b1; #1;
                if (wb_ready) begin
                    exp_r[wb_rd] = wb_data; mask_r[wb_rd] = 1'b1; expected_writes++; pending = 1'b0;
                end
            end
            rx_valid = rx_ready && byte_idx < 4;
            if (rx_valid) begin
                rx_byte = cur_word[31-8*byte_idx -: 8]; byte_idx++;
            end
            @(negedge CLK);
            wb_valid = 1'b0; rx_valid = 1'b0; budget++;
        end
        checks++;
        if (budget >= 50) begin
            fails++; $display("FAIL rand_drain: busy=%b pending=%b after %0d cycles", uart_busy, pending, budget);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (wr_count - base != expected_writes) begin
            fails++; $display("FAIL rand_write_count: got %0d expected %0d", wr_count - base, expected_writes);
        end
        for (int i = 0; i < 32; i++) begin
            if (mask_r[i]) begin
                checks++;
                if (rf_r[i] !== exp_r[i]) begin
                    fails++; $display("FAIL rand_r%0d: got %h expected %h", i, rf_r[i], exp_r[i]);
                end
            end
            if (mask_f[i]) begin
                checks++;
                if (rf_f[i] !== exp_f[i]) begin
                    fails++; $display("FAIL rand_f%0d: got %h expected %h", i, rf_f[i], exp_f[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_wb();
        test_back_to_back();
        test_uart_load();
        test_starvation();
        test_uart_then_wb();
        test_reset_mid_assembly();
        test_r0();
        test_random_mix();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
